// File: rtl/alu_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : alu_secuencial
// Description : Multi-cycle ALU. Captures operands on START, executes
//               single-cycle ops or an iterative shift-add multiply, then
//               publishes registered result and flags with a DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_secuencial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CARRY_OUT,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             SIGNO,
    output logic             ERROR
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_XNOR = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SAR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         sel_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      iter;
    logic               mul_last;
    logic               mul_hi_nz;

    logic [WIDTH-1:0]   ex_out;
    logic               ex_carry;
    logic               ex_ovf;
    logic               ex_err;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     dif_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     sar_ext;

    // After WIDTH iterations the MUL state spends one more cycle publishing.
    assign mul_last  = (iter == CW'(WIDTH));
    assign mul_hi_nz = |acc[2*WIDTH-1:WIDTH];

    // Single-cycle datapath; shifts carry one guard bit to expose the last bit out.
    always_comb begin
        shamt    = b_q[SHW-1:0];
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        dif_ext  = {1'b0, a_q} - {1'b0, b_q};
        shl_ext  = {1'b0, a_q} << shamt;
        shr_ext  = {a_q, 1'b0} >> shamt;
        sar_ext  = $unsigned($signed({a_q, 1'b0}) >>> shamt);
        ex_out   = '0;
        ex_carry = 1'b0;
        ex_ovf   = 1'b0;
        ex_err   = 1'b0;
        case (sel_q)
            OP_ADD: begin
                ex_out   = sum_ext[WIDTH-1:0];
                ex_carry = sum_ext[WIDTH];
                ex_ovf   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                ex_out   = dif_ext[WIDTH-1:0];
                ex_carry = dif_ext[WIDTH];
                ex_ovf   = (a_q[MSB] != b_q[MSB]) && (dif_ext[MSB] != a_q[MSB]);
            end
            OP_AND:  ex_out = a_q & b_q;
            OP_OR:   ex_out = a_q | b_q;
            OP_XOR:  ex_out = a_q ^ b_q;
            OP_NAND: ex_out = ~(a_q & b_q);
            OP_XNOR: ex_out = ~(a_q ^ b_q);
            OP_NOR:  ex_out = ~(a_q | b_q);
            OP_SHL: begin
                ex_out   = shl_ext[WIDTH-1:0];
                ex_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                ex_out   = shr_ext[WIDTH:1];
                ex_carry = shr_ext[0];
            end
            OP_SAR: begin
                ex_out   = sar_ext[WIDTH:1];
                ex_carry = sar_ext[0];
            end
            OP_MUL:  ex_out = '0;
            default: ex_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b1;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    state_next = (SEL == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: state_next = FIN;
            MUL: begin
                if (mul_last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                DONE       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            iter      <= '0;
            ALU_OUT   <= '0;
            CARRY_OUT <= 1'b0;
            OVERFLOW  <= 1'b0;
            ZERO      <= 1'b0;
            SIGNO     <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (START) begin
                        a_q    <= A;
                        b_q    <= B;
                        sel_q  <= SEL;
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        iter   <= '0;
                    end
                end
                EXEC: begin
                    ALU_OUT   <= ex_out;
                    CARRY_OUT <= ex_carry;
                    OVERFLOW  <= ex_ovf;
                    ZERO      <= (ex_out == '0) && !ex_err;
                    SIGNO     <= ex_out[MSB];
                    ERROR     <= ex_err;
                end
                MUL: begin
                    if (!mul_last) begin
                        acc    <= acc + (mplier[0] ? mcand : '0);
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= mplier >> 1;
                        iter   <= iter + CW'(1);
                    end else begin
                        ALU_OUT   <= acc[WIDTH-1:0];
                        CARRY_OUT <= mul_hi_nz;
                        OVERFLOW  <= mul_hi_nz;
                        ZERO      <= (acc[WIDTH-1:0] == '0);
                        SIGNO     <= acc[MSB];
                        ERROR     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
